// File: rtl/wrr_arbiter_ctrl.sv
// Weighted round-robin arbiter: each owner keeps the grant for up to its
// programmed weight in cycles, then the grant rotates with no idle gap.
module wrr_arbiter_ctrl #(
  parameter int N              = 8,
  parameter int WW             = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 wt_wr_en,
  input  logic [$clog2(N)-1:0] wt_wr_idx,
  input  logic [WW-1:0]        wt_wr_data,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_done,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          r_state, w_nxt_state;
  logic [N-1:0]    r_grant, w_nxt_grant;
  logic            r_grant_valid;
  logic [IW-1:0]   r_grant_idx, w_nxt_idx;
  logic [WW-1:0]   r_count, w_nxt_count;
  logic [IW-1:0]   r_last, w_nxt_last;
  logic [WW-1:0]   r_weight [N];

  logic [N-1:0]    w_elig;
  logic [IW-1:0]   w_base, w_cand, w_win;
  logic            w_found, w_done, w_idx_ok;

  assign w_idx_ok = ({1'b0, wt_wr_idx} < (IW+1)'(N));

  // Weight table: a write never touches a running count, and a tenure
  // loading on the same edge reads the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_weight[i] <= WW'(DEFAULT_WEIGHT);
    end else if (wt_wr_en && w_idx_ok) begin
      r_weight[wt_wr_idx] <= wt_wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) w_elig[i] = req[i] && (r_weight[i] != '0);
  end

  // Search starts just after the last owner and checks that owner last,
  // so a lone eligible owner gets re-granted.
  always_comb begin
    w_base  = (r_state == HOLD) ? r_grant_idx : r_last;
    w_cand  = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(w_base) + k >= N) ? IW'(int'(w_base) + k - N)
                                       : IW'(int'(w_base) + k);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_idx   = r_grant_idx;
    w_nxt_count = r_count;
    w_nxt_last  = r_last;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state = HOLD;
          w_nxt_grant = N'(1) << w_win;
          w_nxt_idx   = w_win;
          w_nxt_count = r_weight[w_win];
        end
      end
      HOLD: begin
        w_done = (r_count == WW'(1)) || !req[r_grant_idx];
        if (w_done) begin
          w_nxt_last = r_grant_idx;
          if (w_found) begin
            w_nxt_grant = N'(1) << w_win;
            w_nxt_idx   = w_win;
            w_nxt_count = r_weight[w_win];
          end else begin
            w_nxt_state = IDLE;
            w_nxt_grant = '0;
            w_nxt_idx   = '0;
          end
        end else begin
          w_nxt_count = r_count - WW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_count       <= '0;
      r_last        <= IW'(N - 1);
    end else begin
      r_state       <= w_nxt_state;
      r_grant       <= w_nxt_grant;
      r_grant_valid <= |w_nxt_grant;
      r_grant_idx   <= w_nxt_idx;
      r_count       <= w_nxt_count;
      r_last        <= w_nxt_last;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign grant_done  = w_done;
  assign busy        = (r_state == HOLD);

endmodule

// File: tb/tb_wrr_arbiter_ctrl.sv
// Bench for wrr_arbiter_ctrl (N=4, WW=4): directed scenarios followed by random
// traffic, every cycle compared against a tenure-level reference model.
module tb_wrr_arbiter_ctrl;
  localparam int N    = 4;
  localparam int DEFW = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       grant_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: owner and how many cycles of its tenure have elapsed.
  int m_w [N];
  int m_owner = -1;
  int m_used  = 0;
  int m_len   = 0;
  int m_last  = N - 1;
  bit m_ok    = 1'b0;

  int obs [10];
  int exp_rot [10];
  int exp_rst [4];

  wrr_arbiter_ctrl #(.N(4), .WW(4), .DEFAULT_WEIGHT(DEFW)) dut (
    .clk(clk), .reset(rst), .req(req), .wt_wr_en(wr_en), .wt_wr_idx(wr_idx),
    .wt_wr_data(wr_data), .grant(grant), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .grant_done(grant_done), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit model_done();
    return (m_owner >= 0) && ((m_used == m_len) || !req[2'(m_owner)]);
  endfunction

  task automatic model_edge();
    int base;
    int win;
    if (rst) begin
      m_owner = -1; m_used = 0; m_len = 0; m_last = N - 1; m_ok = 1'b1;
      for (int i = 0; i < N; i++) m_w[i] = DEFW;
      return;
    end
    if (m_owner < 0 || model_done()) begin
      base = (m_owner < 0) ? m_last : m_owner;
      if (m_owner >= 0) m_last = m_owner;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (base + k) % N;
        if (win < 0 && req[2'(c)] && m_w[c] != 0) win = c;
      end
      if (win >= 0) begin
        m_owner = win; m_len = m_w[win]; m_used = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_used++;
    end
    if (wr_en && int'(wr_idx) < N) m_w[wr_idx] = int'(wr_data);
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_ok) chk("grant_done", 32'(grant_done), 32'(model_done()));
    model_edge();
    @(posedge clk);
    #1;
    if (m_ok) begin
      chk("grant",       32'(grant),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("grant_idx",   32'(grant_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("busy",        32'(busy),        32'(m_owner >= 0));
      chk("onehot0",     32'($onehot0(grant)), 32'd1);
    end
  endtask

  task automatic wr(input int idx, input int data);
    wr_en = 1'b1; wr_idx = 2'(idx); wr_data = 4'(data);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    exp_rot = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
    exp_rst = '{0, 1, 2, 3};
    rst = 1'b1; req = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;

    // reset then idle
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_grant", 32'(grant), 32'd0);

    // basic rotation with weights 3,1,2,1
    wr(0, 3); wr(1, 1); wr(2, 2); wr(3, 1);
    req = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs[i] = int'(grant_idx);
    end
    for (int i = 0; i < 10; i++) chk("rotation_seq", 32'(obs[i]), 32'(exp_rot[i]));

    // early release on the 2nd granted cycle
    req = 4'h0; tick(); tick();
    wr(1, 5);
    req = 4'b0010;
    tick(); tick();
    req = 4'h0;
    tick();
    chk("early_grant", 32'(grant), 32'd0);
    chk("early_busy",  32'(busy),  32'd0);

    // masked channel never wins, lone eligible owner is re-granted
    wr(2, 0);
    req = 4'b0100;
    for (int i = 0; i < 5; i++) tick();
    chk("masked_grant", 32'(grant), 32'd0);
    req = 4'h0;
    wr(0, 2);
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("regrant_busy", 32'(grant), 32'd1);
    end

    // write to the owner in its 2nd cycle leaves the running tenure intact
    req = 4'h0; tick(); tick();
    wr(0, 4);
    req = 4'b0001;
    tick(); tick();
    wr(0, 1);
    for (int i = 0; i < 4; i++) tick();

    // reset in the middle of a weight-3 tenure on ch1
    req = 4'h0; tick(); tick();
    wr(1, 3);
    req = 4'b0010;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs[i] = int'(grant_idx);
    end
    for (int i = 0; i < 4; i++) chk("post_rst_seq", 32'(obs[i]), 32'(exp_rst[i]));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req     = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_idx  = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 4));
      rst     = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
